decode_hazard_p: RTL and testbench

DECODE_HAZARD_P -- requirements
Module: decode_hazard_p

---
 rtl/decode_hazard_p.sv | 141 ++++++++++++++
 tb/tb_decode_hazard_p.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_p.sv
// Decode stage: bypassed register file, load-use interlock, branch/jump resolution
// and the ID/EX pipeline register, sequenced by a WAIT/RUN/HALTED controller.
module decode_hazard_p #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  localparam int REG_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  rs_sel,
  input  logic [REG_W-1:0]  rt_sel,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic [REG_W-1:0]  dst_sel,
  input  logic              dst_wr,
  input  logic              dst_is_load,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  input  logic              br_en,
  input  logic [1:0]        br_op,
  input  logic              jmp,
  input  logic              jmp_reg,
  input  logic              halt_in,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_W-1:0]  out_dst_sel,
  output logic              out_dst_wr,
  output logic              out_is_load,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              halted,
  output logic              err
);

  localparam logic [1:0] stWait   = 2'd0;
  localparam logic [1:0] stRun    = 2'd1;
  localparam logic [1:0] stHalted = 2'd2;

  logic [DATA_W-1:0] regFile [NREG];
  logic [1:0]        state;
  logic [DATA_W-1:0] rsData;
  logic [DATA_W-1:0] rtData;
  logic              loadUseStall;
  logic              accept;
  logic              brTaken;
  logic              multiCtrl;

  // A write in flight this cycle is visible to the reader immediately.
  assign rsData = (wb_en && wb_sel == rs_sel) ? wb_data : regFile[rs_sel];
  assign rtData = (wb_en && wb_sel == rt_sel) ? wb_data : regFile[rt_sel];

  assign loadUseStall = out_valid & out_is_load & out_dst_wr &
                        ((rs_used & (rs_sel == out_dst_sel)) |
                         (rt_used & (rt_sel == out_dst_sel)));

  assign in_ready  = (state == stRun) & ~loadUseStall;
  assign accept    = in_valid & in_ready;
  assign halted    = (state == stHalted);
  assign multiCtrl = (jmp & jmp_reg) | (jmp & br_en) | (jmp_reg & br_en);

  always_comb begin
    brTaken = 1'b0;
    case (br_op)
      2'b00:   brTaken = (rsData == '0);
      2'b01:   brTaken = (rsData != '0);
      2'b10:   brTaken = rsData[DATA_W-1];
      default: brTaken = ~rsData[DATA_W-1];
    endcase
  end

  assign redirect = accept & (jmp | jmp_reg | (br_en & brTaken));

  // jmp_reg outranks every other control source when several are set.
  always_comb begin
    redirect_pc = pc;
    if (redirect) begin
      if (jmp_reg) redirect_pc = rsData + imm;
      else         redirect_pc = pc + imm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regFile[i] <= '0;
    end else if (wb_en) begin
      regFile[wb_sel] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= stWait;
      err   <= 1'b0;
    end else begin
      case (state)
        stWait:   state <= stRun;
        stRun:    if (accept && halt_in) state <= stHalted;
        stHalted: state <= stHalted;
        default:  state <= stWait;
      endcase
      if (accept && multiCtrl) err <= 1'b1;
    end
  end

  // Every cycle loads either the accepted instruction or an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm     <= '0;
      out_dst_sel <= '0;
      out_dst_wr  <= 1'b0;
      out_is_load <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_rs_data <= rsData;
      out_rt_data <= rtData;
      out_imm     <= imm;
      out_dst_sel <= dst_sel;
      out_dst_wr  <= dst_wr;
      out_is_load <= dst_is_load;
    end else begin
      out_valid   <= 1'b0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm     <= '0;
      out_dst_sel <= '0;
      out_dst_wr  <= 1'b0;
      out_is_load <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_hazard_p.sv
// Drives a 16-bit/8-reg and a 32-bit/16-reg decode stage with shared stimulus and
// checks both against a per-width reference model, directed tables and sequences.
module tb_decode_hazard_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, rs_used, rt_used, dst_wr, dst_is_load;
  logic        br_en, jmp, jmp_reg, halt_in, wb_en;
  logic [3:0]  rs_sel, rt_sel, dst_sel, wb_sel;
  logic [1:0]  br_op;
  logic [31:0] pc, imm, wb_data;

  logic        rdy0, ov0, odw0, oil0, rd0, h0, e0;
  logic [15:0] ors0, ort0, oim0, rpc0;
  logic [2:0]  ods0;
  logic        rdy1, ov1, odw1, oil1, rd1, h1, e1;
  logic [31:0] ors1, ort1, oim1, rpc1;
  logic [3:0]  ods1;

  decode_hazard_p #(.DATA_W(16), .NREG(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .rs_sel(rs_sel[2:0]), .rt_sel(rt_sel[2:0]), .rs_used(rs_used), .rt_used(rt_used),
    .dst_sel(dst_sel[2:0]), .dst_wr(dst_wr), .dst_is_load(dst_is_load),
    .pc(pc[15:0]), .imm(imm[15:0]), .br_en(br_en), .br_op(br_op), .jmp(jmp),
    .jmp_reg(jmp_reg), .halt_in(halt_in), .wb_en(wb_en), .wb_sel(wb_sel[2:0]),
    .wb_data(wb_data[15:0]), .out_valid(ov0), .out_rs_data(ors0), .out_rt_data(ort0),
    .out_imm(oim0), .out_dst_sel(ods0), .out_dst_wr(odw0), .out_is_load(oil0),
    .redirect(rd0), .redirect_pc(rpc0), .halted(h0), .err(e0));

  decode_hazard_p #(.DATA_W(32), .NREG(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .rs_sel(rs_sel), .rt_sel(rt_sel), .rs_used(rs_used), .rt_used(rt_used),
    .dst_sel(dst_sel), .dst_wr(dst_wr), .dst_is_load(dst_is_load),
    .pc(pc), .imm(imm), .br_en(br_en), .br_op(br_op), .jmp(jmp),
    .jmp_reg(jmp_reg), .halt_in(halt_in), .wb_en(wb_en), .wb_sel(wb_sel),
    .wb_data(wb_data), .out_valid(ov1), .out_rs_data(ors1), .out_rt_data(ort1),
    .out_imm(oim1), .out_dst_sel(ods1), .out_dst_wr(odw1), .out_is_load(oil1),
    .redirect(rd1), .redirect_pc(rpc1), .halted(h1), .err(e1));

  logic [31:0] oRs [2], oRt [2], oImm [2], oRpc [2];
  logic [3:0]  oDst [2];
  logic        oRdy [2], oV [2], oDw [2], oIl [2], oRd [2], oH [2], oE [2];

  assign oRs[0] = {16'h0, ors0};  assign oRs[1] = ors1;
  assign oRt[0] = {16'h0, ort0};  assign oRt[1] = ort1;
  assign oImm[0] = {16'h0, oim0}; assign oImm[1] = oim1;
  assign oRpc[0] = {16'h0, rpc0}; assign oRpc[1] = rpc1;
  assign oDst[0] = {1'b0, ods0};  assign oDst[1] = ods1;
  assign oRdy[0] = rdy0; assign oRdy[1] = rdy1;
  assign oV[0]   = ov0;  assign oV[1]   = ov1;
  assign oDw[0]  = odw0; assign oDw[1]  = odw1;
  assign oIl[0]  = oil0; assign oIl[1]  = oil1;
  assign oRd[0]  = rd0;  assign oRd[1]  = rd1;
  assign oH[0]   = h0;   assign oH[1]   = h1;
  assign oE[0]   = e0;   assign oE[1]   = e1;

  // Reference model state, one copy per width (mode: 0 wait, 1 run, 2 halted).
  int          mMode [2];
  logic [31:0] mRegs [2][16];
  logic        mErr [2], mV [2], mDw [2], mIl [2];
  logic [31:0] mRs [2], mRt [2], mImm [2];
  logic [3:0]  mDst [2];

  int nErr = 0;
  int nChk = 0;
  int cyc  = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] expv);
    nChk++;
    if (act !== expv) begin
      nErr++;
      $display("FAIL %s[w%0d] cyc=%0d: got %h, expected %h", nm, i, cyc, act, expv);
    end
  endtask

  function automatic logic [31:0] msk(int i);
    return (i != 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic logic [3:0] sm(int i, logic [3:0] s);
    return (i != 0) ? s : {1'b0, s[2:0]};
  endfunction

  function automatic logic [31:0] rdReg(int i, logic [3:0] s);
    if (wb_en && sm(i, wb_sel) == sm(i, s)) return wb_data & msk(i);
    return mRegs[i][sm(i, s)];
  endfunction

  function automatic logic mReady(int i);
    logic hazard;
    hazard = mV[i] && mIl[i] && mDw[i] &&
             ((rs_used && sm(i, rs_sel) == mDst[i]) || (rt_used && sm(i, rt_sel) == mDst[i]));
    return (mMode[i] == 1) && !hazard;
  endfunction

  function automatic logic condOk(int i, logic [31:0] r);
    logic neg;
    neg = (i != 0) ? r[31] : r[15];
    case (br_op)
      2'b00:   return r == 32'h0;
      2'b01:   return r != 32'h0;
      2'b10:   return neg;
      default: return !neg;
    endcase
  endfunction

  function automatic logic mRedir(int i);
    return in_valid && mReady(i) && (jmp || jmp_reg || (br_en && condOk(i, rdReg(i, rs_sel))));
  endfunction

  function automatic logic [31:0] mRpc(int i);
    if (!mRedir(i)) return pc & msk(i);
    if (jmp_reg)    return (rdReg(i, rs_sel) + imm) & msk(i);
    return (pc + imm) & msk(i);
  endfunction

  task automatic mReset();
    for (int i = 0; i < 2; i++) begin
      mMode[i] = 0; mErr[i] = 0; mV[i] = 0; mDw[i] = 0; mIl[i] = 0;
      mRs[i] = 0; mRt[i] = 0; mImm[i] = 0; mDst[i] = 0;
      for (int r = 0; r < 16; r++) mRegs[i][r] = 32'h0;
    end
  endtask

  task automatic mClock();
    logic acc;
    logic [31:0] rsv, rtv;
    for (int i = 0; i < 2; i++) begin
      acc = in_valid && mReady(i);
      rsv = rdReg(i, rs_sel);
      rtv = rdReg(i, rt_sel);
      mV[i]   = acc;
      mRs[i]  = acc ? rsv : 32'h0;
      mRt[i]  = acc ? rtv : 32'h0;
      mImm[i] = acc ? (imm & msk(i)) : 32'h0;
      mDst[i] = acc ? sm(i, dst_sel) : 4'h0;
      mDw[i]  = acc && dst_wr;
      mIl[i]  = acc && dst_is_load;
      if (mMode[i] == 0) mMode[i] = 1;
      else if (mMode[i] == 1 && acc && halt_in) mMode[i] = 2;
      if (acc && (int'(jmp) + int'(jmp_reg) + int'(br_en) > 1)) mErr[i] = 1'b1;
      if (wb_en) mRegs[i][sm(i, wb_sel)] = wb_data & msk(i);
    end
  endtask

  task automatic checkComb();
    for (int i = 0; i < 2; i++) begin
      chk("in_ready", i, oRdy[i], mReady(i));
      chk("redirect", i, oRd[i], mRedir(i));
      chk("redirect_pc", i, oRpc[i], mRpc(i));
    end
  endtask

  task automatic checkRegs();
    for (int i = 0; i < 2; i++) begin
      chk("out_valid", i, oV[i], mV[i]);
      chk("out_dst_wr", i, oDw[i], mDw[i]);
      chk("out_is_load", i, oIl[i], mIl[i]);
      chk("halted", i, oH[i], mMode[i] == 2);
      chk("err", i, oE[i], mErr[i]);
      if (mV[i]) begin
        chk("out_rs_data", i, oRs[i], mRs[i]);
        chk("out_rt_data", i, oRt[i], mRt[i]);
        chk("out_imm", i, oImm[i], mImm[i]);
        chk("out_dst_sel", i, oDst[i], mDst[i]);
      end
    end
  endtask

  // Called at the falling edge: compare combinational outputs, clock, compare registers.
  task automatic doCycle();
    checkComb();
    @(posedge clk);
    mClock();
    #1;
    checkRegs();
    $display("cyc %0d in_valid=%0d ready=%0d%0d redirect=%0d%0d pc=%h/%h out_valid=%0d%0d halted=%0d%0d err=%0d%0d",
             cyc, in_valid, rdy0, rdy1, rd0, rd1, rpc0, rpc1, ov0, ov1, h0, h1, e0, e1);
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    doCycle();
  endtask

  task automatic idle();
    in_valid = 0; rs_used = 0; rt_used = 0; dst_wr = 0; dst_is_load = 0;
    br_en = 0; jmp = 0; jmp_reg = 0; halt_in = 0; wb_en = 0; br_op = 2'b00;
    rs_sel = 0; rt_sel = 0; dst_sel = 0; wb_sel = 0; pc = 0; imm = 0; wb_data = 0;
  endtask

  // Entered just after a rising edge; reset is pulled and checked between clock edges.
  task automatic asyncReset();
    #2 rst = 1'b0;
    mReset();
    #1;
    for (int i = 0; i < 2; i++) chk("async_halted", i, oH[i], 1'b0);
    checkRegs();
    checkComb();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        jmp, jmpReg, brEn;
    logic [1:0]  brOp;
    logic [31:0] rsVal, pcV, immV;
    logic [1:0]  expRedir;
    logic [31:0] exp16, exp32;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b1, 2'b10, 32'hFFFF_8000, 32'h0010, 32'hFFFF_FFFE, 2'b11, 32'h000E, 32'h0000_000E};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_0001, 32'h0010, 32'hFFFF_FFFE, 2'b00, 32'h0010, 32'h0000_0010};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0100, 32'h0000_0020, 2'b11, 32'h0120, 32'h0000_0120};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0001_0000, 32'h0100, 32'h0000_0020, 2'b01, 32'h0120, 32'h0000_0100};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0005, 32'h0200, 32'h0000_0004, 2'b11, 32'h0204, 32'h0000_0204};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 2'b11, 32'h0000_7FFF, 32'h0300, 32'h0000_0008, 2'b11, 32'h0308, 32'h0000_0308};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 2'b11, 32'h0000_8000, 32'h0300, 32'h0000_0008, 2'b10, 32'h0300, 32'h0000_0308};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h1000, 32'h0000_0003, 2'b11, 32'h0002, 32'h0000_0002};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'h0040, 32'h0000_0010, 2'b11, 32'h0050, 32'h0000_0050};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'h0040, 32'h0000_0010, 2'b00, 32'h0040, 32'h0000_0040};

    rst = 1'b0;
    idle();
    #16;
    mReset();
    checkRegs();
    checkComb();
    rst = 1'b1;

    // First cycle after reset: halt request must be ignored.
    in_valid = 1; halt_in = 1;
    cycle();
    for (int i = 0; i < 2; i++) chk("wait_halt_ignored", i, oH[i], 1'b0);

    // Same-cycle write bypass into the source read.
    idle();
    in_valid = 1; rs_used = 1; rs_sel = 3; wb_en = 1; wb_sel = 3; wb_data = 32'h0000_1234;
    cycle();
    for (int i = 0; i < 2; i++) chk("bypass_rs", i, oRs[i], 32'h1234);

    // Load-use interlock with a write-back landing during the stall.
    idle();
    in_valid = 1; dst_wr = 1; dst_is_load = 1; dst_sel = 2;
    cycle();
    idle();
    in_valid = 1; rt_used = 1; rt_sel = 2; wb_en = 1; wb_sel = 2; wb_data = 32'hCAFE_0777;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("lu_stall_ready", i, oRdy[i], 1'b0);
    doCycle();
    for (int i = 0; i < 2; i++) chk("lu_bubble", i, oV[i], 1'b0);
    wb_en = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("lu_resume_ready", i, oRdy[i], 1'b1);
    doCycle();
    for (int i = 0; i < 2; i++) begin
      chk("lu_accept_valid", i, oV[i], 1'b1);
      chk("lu_rt_after_wb", i, oRt[i], (i != 0) ? 32'hCAFE_0777 : 32'h0000_0777);
    end

    // Branch/jump redirect table, rs value supplied through the bypass.
    for (int t = 0; t < 10; t++) begin
      idle();
      in_valid = 1; rs_used = 1; rs_sel = 5; wb_en = 1; wb_sel = 5; wb_data = tbl[t].rsVal;
      jmp = tbl[t].jmp; jmp_reg = tbl[t].jmpReg; br_en = tbl[t].brEn; br_op = tbl[t].brOp;
      pc = tbl[t].pcV; imm = tbl[t].immV;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("tbl%0d_redirect", t), i, oRd[i], tbl[t].expRedir[i]);
        chk($sformatf("tbl%0d_pc", t), i, oRpc[i], (i != 0) ? tbl[t].exp32 : tbl[t].exp16);
      end
      doCycle();
    end

    // Conflicting control bits raise a sticky error.
    idle();
    in_valid = 1; jmp = 1; br_en = 1; pc = 32'h80; imm = 32'h4;
    cycle();
    for (int i = 0; i < 2; i++) chk("err_set", i, oE[i], 1'b1);
    idle();
    in_valid = 1;
    cycle();
    for (int i = 0; i < 2; i++) chk("err_sticky", i, oE[i], 1'b1);

    // Halt in RUN, then asynchronous reset clears it.
    idle();
    in_valid = 1; halt_in = 1;
    cycle();
    for (int i = 0; i < 2; i++) chk("halt_entered", i, oH[i], 1'b1);
    idle();
    in_valid = 1; wb_en = 1; wb_sel = 1; wb_data = 32'h5555_AAAA;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("halt_ready", i, oRdy[i], 1'b0);
    doCycle();
    for (int i = 0; i < 2; i++) chk("halt_bubble", i, oV[i], 1'b0);
    asyncReset();

    // Randomized traffic against the model, with periodic asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      int ctl;
      idle();
      in_valid    = ($urandom_range(0, 3) != 0);
      rs_used     = $urandom_range(0, 1);
      rt_used     = $urandom_range(0, 1);
      rs_sel      = 4'($urandom_range(0, 15));
      rt_sel      = 4'($urandom_range(0, 15));
      dst_sel     = 4'($urandom_range(0, 15));
      dst_wr      = $urandom_range(0, 1);
      dst_is_load = ($urandom_range(0, 2) == 0);
      wb_en       = $urandom_range(0, 1);
      wb_sel      = 4'($urandom_range(0, 15));
      wb_data     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      pc          = $urandom;
      imm         = $urandom;
      br_op       = 2'($urandom_range(0, 3));
      halt_in     = ($urandom_range(0, 39) == 0);
      ctl         = $urandom_range(0, 7);
      jmp         = (ctl == 0) || (ctl == 5);
      jmp_reg     = (ctl == 1);
      br_en       = (ctl >= 2 && ctl <= 5);
      cycle();
      if (k % 100 == 99) asyncReset();
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
